uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO and runtime frame configuration.
- Frame format is selectable at runtime: 5–9 data bits via parameter, optional even/odd parity, 1 or 2 stop bits, runtime baud divisor.
- Host pushes words through a valid/ready handshake; frames go out back-to-back with no idle gap while the FIFO holds data.
- Sits between the system bus/register block and the board TX pin.

---
 rtl/uart_tx_fifo_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side push handshake for the UART transmitter FIFO.
// The host (master) offers tx_data with tx_valid; the transmitter (slave)
// accepts when tx_ready is high at a rising edge.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO and runtime frame format
// (data bits by parameter, parity none/even/odd, 1 or 2 stop bits, baud divisor).
// Line-break generation (tx_break input, BREAK and mark-after-break states) is
// built only when the macro UART_TX_BREAK_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for FIFO data (or a break request)
// START  | start bit, line low
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits, line high
// BREAK  | line held low while tx_break stays high
// MAB    | one bit period of mark after a break, then back to IDLE
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                          tx_break,
`endif
  uart_tx_fifo_if.slave                 host,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_MAB    = 3'd6;
`endif

  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  head, shreg;
  logic                  full, empty, push, pop;
  logic [2:0]            state;
  logic [DIV_W-1:0]      cnt, ldiv, eff_div;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx, par_en, par_bit, two_stop_l;
  logic                  idle_brk;

`ifdef UART_TX_BREAK_EN
  assign idle_brk = tx_break;
`else
  assign idle_brk = 1'b0;
`endif

  assign fifo_level    = wr_ptr - rd_ptr;
  assign full          = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign empty         = (wr_ptr == rd_ptr);
  assign host.tx_ready = ~full;
  assign push          = host.tx_valid & ~full;
  assign head          = mem[rd_ptr[AW-1:0]];
  assign tx_busy       = (state != S_IDLE) | ~empty;
  // divisors below two would leave no room for a down-count, so clamp to two
  assign eff_div       = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;

  // pop the head when idle (unless a break wins) or at the end of the last stop bit
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE)
        pop = ~idle_brk;
      else if (state == S_STOP && cnt == '0 && (stop_idx || !two_stop_l))
        pop = 1'b1;
    end
  end

  // FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= host.tx_data;
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // frame sequencer: bit timer counts down, state advances when it reaches zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      cnt        <= '0;
      ldiv       <= DIV_W'(2);
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      two_stop_l <= 1'b0;
    end else begin
      if (state != S_IDLE && cnt != '0) begin
        cnt <= cnt - DIV_W'(1);
      end else begin
        case (state)
          S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (tx_break) begin
              state <= S_BREAK;
              txd   <= 1'b0;
            end
`endif
          end
          S_START: begin
            txd     <= shreg[0];
            bit_idx <= '0;
            cnt     <= ldiv - DIV_W'(1);
            state   <= S_DATA;
          end
          S_DATA: begin
            cnt <= ldiv - DIV_W'(1);
            if (bit_idx == BW'(DATA_BITS-1)) begin
              if (par_en) begin
                txd   <= par_bit;
                state <= S_PARITY;
              end else begin
                txd      <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              txd     <= shreg[1];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end
          S_PARITY: begin
            txd      <= 1'b1;
            stop_idx <= 1'b0;
            cnt      <= ldiv - DIV_W'(1);
            state    <= S_STOP;
          end
          S_STOP: begin
            if (!stop_idx && two_stop_l) begin
              stop_idx <= 1'b1;
              cnt      <= ldiv - DIV_W'(1);
            end else begin
              state <= S_IDLE;
            end
          end
`ifdef UART_TX_BREAK_EN
          S_BREAK: begin
            if (!tx_break) begin
              txd   <= 1'b1;
              cnt   <= eff_div - DIV_W'(1);
              state <= S_MAB;
            end
          end
          S_MAB: begin
            state <= S_IDLE;
          end
`endif
          default: begin
            state <= S_IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
      // a pop starts a new frame and overrides whatever the case above chose
      if (pop) begin
        shreg      <= head;
        ldiv       <= eff_div;
        cnt        <= eff_div - DIV_W'(1);
        par_en     <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit    <= (^head) ^ (parity_mode == 2'b10);
        two_stop_l <= two_stop;
        txd        <= 1'b0;
        state      <= S_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo, checked
// cycle by cycle against a queue-based line model (FIFO as a queue of words,
// line as a queue of per-clock txd values built from the frame rules).
module tb_uart_tx_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] baud_div;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          tb_break;
  logic          txd, tx_busy;
  logic [2:0]    fifo_level;

  uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();

  uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
    .tx_break    (tb_break),
`endif
    .host        (bus),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model state
  logic [DB-1:0] mq[$];
  bit            sq[$];
  int            mode = 0;        // 0 normal, 1 break, 2 mark-after-break
  int            mark_left = 0;
  bit            line_busy = 0;
  bit            exp_txd = 1;
  bit            acc = 0;

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_edge();
    int pre, d;
    logic [DB-1:0] w;
    bit prev_busy;
    acc = 0;
    if (!nrst) begin
      mq.delete(); sq.delete();
      mode = 0; line_busy = 0; exp_txd = 1;
      return;
    end
    pre = mq.size();
    prev_busy = line_busy;
    if (mode == 1) begin
      line_busy = 1;
      if (!tb_break) begin
        mode = 2; mark_left = eff(int'(baud_div)) - 1; exp_txd = 1;
      end else exp_txd = 0;
    end else if (mode == 2) begin
      exp_txd = 1;
      if (mark_left == 0) begin mode = 0; line_busy = 0; end
      else begin mark_left--; line_busy = 1; end
    end else if (!prev_busy && sq.size() == 0 && tb_break) begin
      mode = 1; exp_txd = 0; line_busy = 1;
    end else begin
      if (sq.size() == 0 && pre > 0) begin
        w = mq.pop_front();
        d = eff(int'(baud_div));
        repeat (d) sq.push_back(1'b0);
        for (int i = 0; i < DB; i++) repeat (d) sq.push_back(w[i]);
        if (parity_mode == 2'b01 || parity_mode == 2'b10)
          repeat (d) sq.push_back((^w) ^ (parity_mode == 2'b10));
        repeat (two_stop ? 2*d : d) sq.push_back(1'b1);
      end
      if (sq.size() > 0) begin exp_txd = sq.pop_front(); line_busy = 1; end
      else begin exp_txd = 1; line_busy = 0; end
    end
    if (bus.tx_valid && pre < DEPTH) begin
      mq.push_back(bus.tx_data);
      acc = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("txd", txd, exp_txd);
    check_val("tx_busy", tx_busy, line_busy || mq.size() > 0);
    check_val("tx_ready", bus.tx_ready, mq.size() < DEPTH);
    check_val("fifo_level", fifo_level, mq.size());
  endtask

  task automatic run_idle(input int n);
    bus.tx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_word(input logic [DB-1:0] d);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    for (int i = 0; i < 400; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check_val("push_accepted", acc, 1);
    bus.tx_valid = 1'b0;
  endtask

  // frame from an idle line: busy stays high for one latency clock plus the frame
  task automatic frame_len(input logic [DB-1:0] d, input int exp_len, input string tag);
    int n = 0;
    push_word(d);
    while (tx_busy && n < 500) begin step(); n++; end
    check_val(tag, n, exp_len);
  endtask

  task automatic run_random(input int cycles, input int p_valid);
    for (int i = 0; i < cycles; i++) begin
      if (!bus.tx_valid && $urandom_range(99) < p_valid) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = DB'($urandom);
      end
      if ($urandom_range(99) == 0) begin
        baud_div    = DW'($urandom_range(0, 5));
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
`ifdef UART_TX_BREAK_EN
      if ($urandom_range(299) == 0) tb_break = ~tb_break;
`endif
      step();
      if (acc) bus.tx_valid = 1'b0;
    end
    bus.tx_valid = 1'b0;
    tb_break = 1'b0;
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    baud_div     = 16'd4;
    parity_mode  = 2'b00;
    two_stop     = 1'b0;
    tb_break     = 1'b0;
    nrst         = 1'b0;
    repeat (3) step();
    check_val("rst_txd", txd, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_ready", bus.tx_ready, 1);
    check_val("rst_level", fifo_level, 0);
    nrst = 1'b1;
    run_idle(3);

    // 8N1 at div 4: 40-clock frame plus one clock from push to start bit
    frame_len(8'hA5, 41, "frame_8n1_len");
    run_idle(3);
    // 8E2 and 8O2 at div 4: 48-clock frame
    parity_mode = 2'b01; two_stop = 1'b1;
    frame_len(8'h07, 49, "frame_8e2_len");
    parity_mode = 2'b10;
    frame_len(8'h07, 49, "frame_8o2_len");
    parity_mode = 2'b00; two_stop = 1'b0;
    run_idle(3);

    // burst of five words into a four-deep FIFO
    for (int i = 0; i < 5; i++) push_word(DB'($urandom));
    run_idle(230);

    // minimum divisors
    baud_div = 16'd0;
    push_word(8'h3C); push_word(8'hC3);
    run_idle(50);
    baud_div = 16'd1;
    push_word(8'h81); push_word(8'h7E);
    run_idle(50);

    // divisor change mid-frame only affects the following frame
    baud_div = 16'd4;
    push_word(8'h55); push_word(8'hAA);
    run_idle(10);
    baud_div = 16'd8;
    run_idle(140);

    // reset during a data bit with words queued
    baud_div = 16'd4;
    for (int i = 0; i < 4; i++) push_word(DB'($urandom));
    run_idle(6);
    nrst = 1'b0;
    #1;
    check_val("mid_rst_txd", txd, 1);
    check_val("mid_rst_level", fifo_level, 0);
    check_val("mid_rst_busy", tx_busy, 0);
    check_val("mid_rst_ready", bus.tx_ready, 1);
    repeat (2) step();
    nrst = 1'b1;
    run_idle(40);

`ifdef UART_TX_BREAK_EN
    // 20-clock break with a word queued behind it, then mark-after-break
    baud_div = 16'd4;
    tb_break = 1'b1;
    push_word(8'hF0);
    repeat (19) step();
    tb_break = 1'b0;
    run_idle(60);
`endif

    run_random(4000, 40);
    run_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
